// File: rtl/conversor_if.sv
// Signal bundle for the serial-to-parallel converter. The stimulus side drives
// the serial bit and the patterns. The converter returns the flags, frame and serial echo.
interface conversor_if #(
  parameter int W = 4
);
  logic         entrada_serie;
  logic [W-1:0] patron_A;
  logic [W-1:0] patron_B;
  logic [W-1:0] patron_C;
  logic         out_A;
  logic         out_B;
  logic         out_C;
  logic [W-1:0] out_par;
  logic         out_serie;

  modport master (
    output entrada_serie, patron_A, patron_B, patron_C,
    input  out_A, out_B, out_C, out_par, out_serie
  );

  modport slave (
    input  entrada_serie, patron_A, patron_B, patron_C,
    output out_A, out_B, out_C, out_par, out_serie
  );
endinterface

// File: rtl/conversor.sv
// Serial-to-parallel converter with a three-pattern sliding-window detector.
// Each completed W-bit frame is also re-emitted serially, MSB first.
module conversor #(
  parameter int W = 4
) (
  input  logic       clk,
  input  logic       rst,
  conversor_if.slave bus
);
  localparam int FW = $clog2(W + 1);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_sr;
  logic [W-1:0]  r_tx;
  logic [W-1:0]  r_par;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_fc;
  logic [2:0]    r_flag;

  logic [W-1:0]  w_sr_n;
  logic [FW-1:0] w_fill_n;
  logic          w_full;
  logic          w_frame_end;
  logic [W-1:0]  w_pat [3];
  logic [2:0]    w_hit;

  always_comb begin
    w_sr_n      = {r_sr[W-2:0], bus.entrada_serie};
    w_fill_n    = (r_fill == FW'(W)) ? r_fill : r_fill + FW'(1);
    w_full      = (w_fill_n == FW'(W));
    w_frame_end = (r_fc == CW'(W - 1));
  end

  assign w_pat[0] = bus.patron_A;
  assign w_pat[1] = bus.patron_B;
  assign w_pat[2] = bus.patron_C;

  // A match only counts once the window holds W real samples, not reset zeros.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_match
      assign w_hit[gi] = w_full && (w_sr_n == w_pat[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_tx   <= '0;
      r_par  <= '0;
      r_fill <= '0;
      r_fc   <= '0;
      r_flag <= '0;
    end else begin
      r_sr   <= w_sr_n;
      r_fill <= w_fill_n;
      r_flag <= w_hit;
      r_fc   <= w_frame_end ? '0 : r_fc + CW'(1);
      // Frames are back-to-back, so a new load always replaces the last shifted bit.
      if (w_frame_end) begin
        r_par <= w_sr_n;
        r_tx  <= w_sr_n;
      end else begin
        r_tx  <= {r_tx[W-2:0], 1'b0};
      end
    end
  end

  assign bus.out_A     = r_flag[0];
  assign bus.out_B     = r_flag[1];
  assign bus.out_C     = r_flag[2];
  assign bus.out_par   = r_par;
  assign bus.out_serie = r_tx[W-1];
endmodule

// File: tb/tb_conversor.sv
// Self-checking bench for conversor: directed vector table plus randomized
// stream compared against a bit-history reference model.
module tb_conversor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conversor_if #(.W(W)) bus();
  conversor #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic d);
    rst = r;
    bus.entrada_serie = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       d;
    logic [2:0] fl;   // {A,B,C}
    logic [3:0] par;
    logic       ser;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic d, input logic [2:0] fl,
                              input logic [3:0] par, input logic ser);
    vec_t v;
    v.r = r; v.d = d; v.fl = fl; v.par = par; v.ser = ser;
    tbl.push_back(v);
  endfunction

  // Reference model: full bit history since reset, frame held separately.
  bit         hist[$];
  logic [3:0] m_par;

  function automatic logic [3:0] window();
    logic [3:0] v = '0;
    int n = hist.size();
    for (int i = 0; i < W; i++) v[W-1-i] = hist[n-W+i];
    return v;
  endfunction

  initial begin
    logic [3:0] pa, pb, pc, win;
    logic [2:0] efl;
    logic       eser, d, r;
    int         n, both_hi;

    rst = 1'b1;
    bus.entrada_serie = 1'b0;
    bus.patron_A = 4'b1001;
    bus.patron_B = 4'b1100;
    bus.patron_C = 4'b0011;

    // Reset with random data, then 1,0,0,1 and three trailing zeros.
    add(1, 1'($urandom), 3'b000, 4'b0000, 0);
    add(1, 1'($urandom), 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b100, 4'b1001, 1);
    add(0, 0, 3'b000, 4'b1001, 0);
    add(0, 0, 3'b000, 4'b1001, 0);
    add(0, 0, 3'b000, 4'b1001, 1);
    // 1,1,0,0,1,1: B at 4, window 1001 hits A at 5, C at 6
    add(1, 0, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b010, 4'b1100, 1);
    add(0, 1, 3'b100, 4'b1100, 1);
    add(0, 1, 3'b001, 4'b1100, 0);
    // 0,1,1 with window not full, then 0 -> 0110
    add(1, 0, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0110, 0);
    // two bits, mid-frame reset, then 1,0,0,1
    add(1, 0, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(1, 0, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0000, 0);
    add(0, 0, 3'b000, 4'b0000, 0);
    add(0, 1, 3'b100, 4'b1001, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].d);
      $display("vec %0d rst=%b din=%b flags=%b%b%b par=%b ser=%b", i, tbl[i].r, tbl[i].d,
               bus.out_A, bus.out_B, bus.out_C, bus.out_par, bus.out_serie);
      chk($sformatf("vec%0d_flags", i), {5'b0, bus.out_A, bus.out_B, bus.out_C}, {5'b0, tbl[i].fl});
      chk($sformatf("vec%0d_par", i), {4'b0, bus.out_par}, {4'b0, tbl[i].par});
      chk($sformatf("vec%0d_serie", i), {7'b0, bus.out_serie}, {7'b0, tbl[i].ser});
    end

    // Randomized stream; first 64 cycles use A=B=1111 on a ones-heavy stream.
    step(1, 0);
    hist.delete();
    m_par   = '0;
    both_hi = 0;
    for (int c = 0; c < 256; c++) begin
      if (c < 64) begin
        bus.patron_A = 4'b1111;
        bus.patron_B = 4'b1111;
        if (c % 16 == 0) bus.patron_C = 4'($urandom);
        d = ($urandom_range(0, 3) != 0);
      end else begin
        if (c % 16 == 0) begin
          bus.patron_A = 4'($urandom);
          bus.patron_B = ($urandom_range(0, 1) != 0) ? bus.patron_A : 4'($urandom);
          bus.patron_C = 4'($urandom);
        end
        d = 1'($urandom);
      end
      r  = (c > 8) && ($urandom_range(0, 47) == 0);
      pa = bus.patron_A; pb = bus.patron_B; pc = bus.patron_C;

      if (r) begin
        hist.delete();
        m_par = '0;
      end else begin
        hist.push_back(d);
      end
      n    = hist.size();
      win  = (n >= W) ? window() : 4'b0000;
      efl  = (n >= W) ? {win == pa, win == pb, win == pc} : 3'b000;
      if (n >= W && n % W == 0) m_par = win;
      eser = (n >= W) ? hist[n-W] : 1'b0;

      step(r, d);
      $display("rnd %0d rst=%b din=%b flags=%b%b%b par=%b ser=%b", c, r, d,
               bus.out_A, bus.out_B, bus.out_C, bus.out_par, bus.out_serie);
      if (c < 64 && bus.out_A && bus.out_B) both_hi++;
      chk($sformatf("rnd%0d_flags", c), {5'b0, bus.out_A, bus.out_B, bus.out_C}, {5'b0, efl});
      chk($sformatf("rnd%0d_par", c), {4'b0, bus.out_par}, {4'b0, m_par});
      chk($sformatf("rnd%0d_serie", c), {7'b0, bus.out_serie}, {7'b0, eser});
    end
    checks++;
    if (both_hi == 0) begin
      failures++;
      $display("FAIL both_flags_seen: got %0d cycles with A and B high required >0", both_hi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
